// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer: parallel-to-serial DDR transmitter.
// Words are accepted on a valid/ready handshake and shifted out MSB first,
// one bit in the high phase and one in the low phase of each clock cycle.
// The DDR line uses a posedge flop and a negedge flop, XOR-combined, so no
// vendor DDR primitive is needed. WIDTH must be even and at least 4.
`timescale 1ns / 1ps

module ddr_tx_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetq,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             frame,
  output logic             busy
);

  // Pair counter width; a word of WIDTH bits takes WIDTH/2 cycles.
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic             fbit_q;
  logic             frame_q;
  logic             rp_q;
  logic             np_q;

  logic             accept;
  logic             more_pairs;
  logic             rise_d;

  // Ready is built from registers only: idle, or the last pair is on the line.
  assign in_ready   = (state_q == IDLE) || (cnt_q == '0);
  assign accept     = in_valid && in_ready;
  assign more_pairs = (state_q == SHIFT) && (cnt_q != '0);

  // High-phase bit for the cycle that begins at the coming posedge.
  always_comb begin
    // NOTE: default assignment first so every path drives rise_d and no latch is inferred.
    rise_d = 1'b0;
    if (accept) begin
      rise_d = in_data[WIDTH-1];
    end else if (more_pairs) begin
      rise_d = sr_q[WIDTH-1];
    end
  end

  // Control FSM, shift register, fall bit and the posedge half of the line.
  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      fbit_q  <= 1'b0;
      frame_q <= 1'b0;
      rp_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values, np_q included.
      // Cancel the negedge flop's contribution so dout shows rise_d.
      rp_q <= rise_d ^ np_q;
      if (accept) begin
        fbit_q  <= in_data[WIDTH-2];
        sr_q    <= in_data << 2;
        cnt_q   <= CNT_LAST;
        state_q <= SHIFT;
        frame_q <= 1'b1;
      end else if (more_pairs) begin
        fbit_q  <= sr_q[WIDTH-2];
        sr_q    <= sr_q << 2;
        cnt_q   <= cnt_q - CW'(1);
      end else begin
        fbit_q  <= 1'b0;
        state_q <= IDLE;
        frame_q <= 1'b0;
      end
    end
  end

  // Low-phase half of the line; a half-cycle path from fbit_q and rp_q.
  always_ff @(negedge clock or negedge resetq) begin
    if (!resetq) begin
      np_q <= 1'b0;
    end else begin
      np_q <= fbit_q ^ rp_q;
    end
  end

  assign dout  = rp_q ^ np_q;
  assign frame = frame_q;
  assign busy  = (state_q == SHIFT);

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Testbench for ddr_tx_serializer: three instances (WIDTH 4, 8, 16) each
// checked every half-cycle against a bit-queue model of the line, plus a word
// scoreboard that rebuilds words from dout while frame is high. The WIDTH=8
// lane also gets directed sequences with hand-computed literal expectations.
`timescale 1ns / 1ps

module tb_ddr_tx_serializer;

  localparam int NL = 3;

  logic          clock;
  logic          resetq;
  logic [15:0]   in_data [NL];
  logic [NL-1:0] in_valid;
  logic [NL-1:0] in_ready;
  logic [NL-1:0] dout;
  logic [NL-1:0] frame;
  logic [NL-1:0] busy;

  int total = 0;
  int bad   = 0;
  int words_done [NL];
  int pending    [NL];

  // Capture of the WIDTH=8 lane for directed sequences.
  bit cap_en = 0;
  bit cap  [$];
  bit capf [$];
  bit capr [$];

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    localparam logic [15:0] MASK = 16'((32'd1 << W) - 1);

    bit          q    [$];  // expected line bits; front pair is the current cycle
    logic [15:0] sent [$];  // words the model accepted, oldest first
    logic [15:0] acc;
    int          nacc;

    ddr_tx_serializer #(.WIDTH(W)) u_dut (
      .clock    (clock),
      .resetq   (resetq),
      .in_data  (in_data[g][W-1:0]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .dout     (dout[g]),
      .frame    (frame[g]),
      .busy     (busy[g])
    );

    initial begin
      acc  = '0;
      nacc = 0;
    end

    always begin
      @(posedge clock);
      if (!resetq) begin
        q.delete();
        sent.delete();
        nacc = 0;
      end else begin
        if (q.size() >= 2) begin
          void'(q.pop_front());
          void'(q.pop_front());
        end
        if (q.size() == 0 && in_valid[g]) begin
          for (int i = W - 1; i >= 0; i--) q.push_back(in_data[g][i]);
          sent.push_back(in_data[g] & MASK);
        end
      end
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) #5;
        else #10;
        if (!resetq) begin
          q.delete();
          sent.delete();
          nacc = 0;
          check($sformatf("w%0d reset dout", W), dout[g], 1'b0);
          check($sformatf("w%0d reset frame", W), frame[g], 1'b0);
          check($sformatf("w%0d reset busy", W), busy[g], 1'b0);
          check($sformatf("w%0d reset ready", W), in_ready[g], 1'b1);
        end else begin
          check($sformatf("w%0d dout ph%0d", W, ph), dout[g], (q.size() > 0) ? q[ph] : 1'b0);
          check($sformatf("w%0d frame", W), frame[g], q.size() > 0);
          if (ph == 0) begin
            check($sformatf("w%0d busy", W), busy[g], q.size() > 0);
            check($sformatf("w%0d in_ready", W), in_ready[g], q.size() <= 2);
          end
          if (frame[g]) begin
            acc = {acc[14:0], dout[g]};
            nacc++;
            if (nacc == W) begin
              check($sformatf("w%0d word", W), 32'(acc & MASK),
                    (sent.size() > 0) ? 32'(sent.pop_front()) : 32'hDEAD_0000);
              words_done[g]++;
              nacc = 0;
            end
          end
        end
        pending[g] = sent.size();
        if (g == 1 && cap_en) begin
          cap.push_back(dout[g]);
          if (ph == 0) begin
            capf.push_back(frame[g]);
            capr.push_back(in_ready[g]);
          end
        end
      end
    end
  end

  // Advance to 17/20 of the next cycle, after both phase samples.
  task automatic step();
    @(posedge clock);
    #17;
  endtask

  task automatic drive8(input logic v, input logic [15:0] d);
    in_valid[1] = v;
    in_data[1]  = d;
  endtask

  task automatic cap_start();
    cap.delete();
    capf.delete();
    capr.delete();
    cap_en = 1;
  endtask

  task automatic cap_check(input string name, input int ncyc, input logic [31:0] exp_bits,
                           input logic [15:0] exp_f, input logic [15:0] exp_r);
    logic [31:0] b;
    logic [15:0] f;
    logic [15:0] r;
    b = '0;
    f = '0;
    r = '0;
    cap_en = 0;
    foreach (cap[i])  b = {b[30:0], cap[i]};
    foreach (capf[i]) f = {f[14:0], capf[i]};
    foreach (capr[i]) r = {r[14:0], capr[i]};
    check({name, " length"}, cap.size(), 2 * ncyc);
    check({name, " bits"}, b, exp_bits);
    check({name, " frame"}, 32'(f), 32'(exp_f));
    check({name, " ready"}, 32'(r), 32'(exp_r));
  endtask

  initial begin
    resetq   = 1'b0;
    in_valid = '0;
    for (int g = 0; g < NL; g++) begin
      in_data[g]    = '0;
      words_done[g] = 0;
      pending[g]    = 0;
    end
    #1;
    check("por dout", dout[1], 1'b0);
    check("por ready", in_ready[1], 1'b1);
    repeat (3) step();
    resetq = 1'b1;
    step();

    // Single word 0xA5.
    drive8(1'b1, 16'h00A5);
    cap_start();
    step();
    drive8(1'b0, 16'h0000);
    repeat (5) step();
    cap_check("single", 6, 32'b1010_0101_0000, 16'b111100, 16'b000111);

    // Back-to-back 0xA5, 0x3C.
    drive8(1'b1, 16'h00A5);
    cap_start();
    step();
    drive8(1'b1, 16'h003C);
    repeat (4) step();
    drive8(1'b0, 16'h0000);
    repeat (5) step();
    cap_check("b2b", 10, 32'hA53C0, 16'b1111111100, 16'b0001000111);

    // Gapped source: 0xFF, three idle cycles, 0x01.
    drive8(1'b1, 16'h00FF);
    cap_start();
    step();
    drive8(1'b0, 16'h0000);
    repeat (6) step();
    drive8(1'b1, 16'h0001);
    step();
    drive8(1'b0, 16'h0000);
    repeat (5) step();
    cap_check("gap", 13, 32'b11111111_000000_00000001_0000, 16'b1111000111100, 16'b0001111000111);

    // Stall: data changes while not ready; only accepting-edge data is sent.
    drive8(1'b1, 16'h005A);
    cap_start();
    step();
    drive8(1'b1, 16'h0011);
    step();
    drive8(1'b1, 16'h0022);
    step();
    drive8(1'b1, 16'h0033);
    step();
    drive8(1'b1, 16'h00C3);
    step();
    drive8(1'b0, 16'h0000);
    repeat (4) step();
    cap_check("stall", 9, 32'b01011010_11000011_00, 16'b111111110, 16'b000100011);

    // Asynchronous reset in the middle of a word.
    drive8(1'b1, 16'h00FF);
    step();
    drive8(1'b0, 16'h0000);
    @(posedge clock);
    #3;
    check("pre-reset dout", dout[1], 1'b1);
    resetq = 1'b0;
    #1;
    check("async reset dout", dout[1], 1'b0);
    check("async reset frame", frame[1], 1'b0);
    check("async reset busy", busy[1], 1'b0);
    check("async reset ready", in_ready[1], 1'b1);
    #13;
    repeat (2) step();
    resetq = 1'b1;
    cap_start();
    repeat (10) step();
    cap_check("post-reset idle", 10, 32'h0, 16'h0, 16'h3FF);

    // Random words with random valid gaps on all widths, one mid-run reset.
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) resetq = 1'b0;
      if (n == 2002) resetq = 1'b1;
      for (int g = 0; g < NL; g++) begin
        in_valid[g] = ($urandom_range(0, 3) != 0);
        in_data[g]  = 16'($urandom);
      end
      step();
    end
    in_valid = '0;
    repeat (12) step();
    for (int g = 0; g < NL; g++) begin
      check($sformatf("lane%0d words left", g), pending[g], 0);
      check($sformatf("lane%0d words seen", g), words_done[g] > 100, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_tx_serializer.md
# ddr_tx_serializer

Parallel-to-serial transmitter that drives one data bit per clock half-period: one bit in the high phase and one in the low phase of `clock`. It accepts words over a valid/ready handshake and shifts them out MSB first, two bits per cycle, on a single double-data-rate line with a frame qualifier. It is the transmit counterpart of the team's dual-edge capture logic. It is built entirely in fabric flip-flops (one posedge register, one negedge register, XOR-combined), so it needs no vendor DDR I/O primitive.

## Interface
- `WIDTH`, default 8: word width in bits; must be even and ≥ 4.
- `clock`  input  1  system clock; both edges used.
- `resetq`  input  1  asynchronous, active-low reset.
- `in_data`  input  WIDTH  word to transmit; sampled only on an accepting posedge.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block will accept a word at the next posedge.
- `dout`  output  1  DDR serial data.
- `frame`  output  1  high for every cycle in which `dout` carries data; changes only at posedge.
- `busy`  output  1  a word is in flight.

## Operation
- The posedge domain holds all control: state (IDLE/SHIFT), pair counter `cnt` (width clog2(WIDTH/2)), shift register `sr`, and registered fall bit `fbit`.
- Output construction:
  - posedge register `rp` and negedge register `np`; `dout = rp ^ np`.
  - At posedge: `rp <= rise_bit ^ np`. At negedge: `np <= fbit ^ rp`.
  - Result: `dout` equals `rise_bit` in the high phase and `fbit` in the low phase. Only one register changes per edge.
- `in_ready = (state==IDLE) || (cnt==0)`. It is derived from registers only and never depends on `in_valid` combinationally.
- Accept occurs at a posedge with `in_valid & in_ready`:
  - `rise_bit = in_data[WIDTH-1]`, `fbit <= in_data[WIDTH-2]`.
  - `sr <= in_data << 2`, `cnt <= WIDTH/2-1`, state SHIFT, `frame <= 1`.
- SHIFT with `cnt != 0` at a posedge: `rise_bit = sr[WIDTH-1]`, `fbit <= sr[WIDTH-2]`, `sr <= sr << 2`, `cnt <= cnt-1`.
- SHIFT with `cnt == 0` at a posedge:
  - If accepting, start the new word with no gap (back-to-back streaming).
  - Otherwise go to IDLE with `rise_bit = 0`, `fbit <= 0`, `frame <= 0`.
- IDLE: `dout` is 0 in both phases; `frame` is 0.
- `busy = (state==SHIFT)`.
- Bit order per word: d[W-1] (high phase), d[W-2] (low phase), d[W-3], d[W-4], … d[1], d[0].
- Reset (async, any time, including mid-word):
  - `rp`, `np`, `sr`, `fbit`, `cnt` = 0; state IDLE.
  - Outputs: `dout = 0`, `frame = 0`, `busy = 0`, `in_ready = 1`.
  - The in-flight word is discarded. After release, the first posedge may accept.

## Timing
- Latency is zero cycles. `dout` shows d[W-1] during the high phase right after the accepting posedge k, and d[W-2] during the following low phase.
- A word occupies exactly WIDTH/2 cycles (edges k … k+WIDTH/2-1). `frame` is high over the same span.
- `in_ready` goes low after edge k when WIDTH > 2. It returns high after edge k+WIDTH/2-1, so the next accept can happen at k+WIDTH/2.
- Sustained throughput: 2 bits per clock with `in_valid` held high.
- The negedge capture of `fbit` and `rp` is a half-cycle path and must meet timing at half the clock period.
- `dout` must be sampled by the bench at roughly ¼ and ¾ of the period, not at the edges.

## Test plan
- Reset: assert `resetq=0` mid-SHIFT. Required: `dout=0`, `frame=0`, `busy=0`, `in_ready=1` immediately, without waiting for an edge. After release with `in_valid=0`, `dout` stays 0 for 10 cycles.
- Single word, WIDTH=8, 0xA5 accepted at edge 0. Required:
  - `dout` sequence 1,0 | 1,0 | 0,1 | 0,1 over cycles 0–3.
  - `frame` high for cycles 0–3 and low from edge 4.
  - `in_ready` low after edges 0–2 and high after edge 3.
- Back-to-back: 0xA5 then 0x3C with `in_valid` held high. Required: 16 contiguous bits 10100101 00111100, `frame` high for 8 cycles, no idle phase between words.
- Gapped source: `in_valid` drops for 3 cycles between 0xFF and 0x01. Required: `frame` low for exactly 3 cycles; `dout=0` during the gap; second word is 00000001.
- Stall: `in_valid` high with changing `in_data` while `in_ready=0`. Required: transmitted word equals `in_data` at the accepting edge only.
- Parameter sweep with WIDTH=4 and WIDTH=16, random words and random valid gaps. The scoreboard's reconstructed words must match the inputs exactly and in order.
